// File: rtl/led_seq_pkg.sv
// Purpose: shared encodings for the LED sequencer (modes, FSM states, bounce direction).
// Ports:   none (package only).
// Used by: led_seq_ctrl and its testbench.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/led_seq_ctrl_stb_div.sv
// Purpose: reloadable down-counter generating the shift strobe; period is load value + 1.
// Ports:   i_load/i_load_val preset the count, i_en lets it count, o_tc flags count==0 while enabled.
// Timing:  o_tc is combinational from the count; it reloads from i_load_val on the same edge.
module stb_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_load_val,
  input  logic                 i_en,
  output logic                 o_tc
);

  logic [DIV_WIDTH-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load || o_tc) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Purpose: accepts {mode, div, pattern} commands via valid/ready and steps a registered LED
//          shift pattern (hold / rotate left / rotate right / bounce) on an internal strobe.
// Ports:   i_cmd_* command handshake, i_pause freeze level, o_led/o_stb/o_busy status outputs.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LED_COUNT = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_mode,
  input  logic [DIV_WIDTH-1:0] i_cmd_div,
  input  logic [LED_COUNT-1:0] i_cmd_pattern,
  input  logic                 i_pause,
  output logic [LED_COUNT-1:0] o_led,
  output logic                 o_stb,
  output logic                 o_busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  mode_t                r_mode;
  dir_t                 r_dir;
  dir_t                 w_dir_step;
  logic [DIV_WIDTH-1:0] r_div;
  logic [LED_COUNT-1:0] r_pat;
  logic [LED_COUNT-1:0] r_led;
  logic [LED_COUNT-1:0] w_led_step;
  logic [LED_COUNT-1:0] w_rotl;
  logic [LED_COUNT-1:0] w_rotr;
  logic                 r_stb;
  logic                 w_accept;
  logic                 w_cnt_load;
  logic                 w_cnt_en;
  logic                 w_tc;

  assign o_cmd_ready = (r_state != ST_LOAD);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_led       = r_led;
  assign o_stb       = r_stb;
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  // Counter only runs in RUN on edges with no new command and no pause, so an
  // accept or pause edge can never produce a step.
  stb_div #(.DIV_WIDTH(DIV_WIDTH)) u_stb_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (r_div),
    .i_en       (w_cnt_en),
    .o_tc       (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept)     w_state_nxt = ST_LOAD;
        else if (i_pause) w_state_nxt = ST_PAUSE;
        else              w_cnt_en    = 1'b1;
      end
      ST_PAUSE: begin
        if (w_accept)      w_state_nxt = ST_LOAD;
        else if (!i_pause) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rotl = {r_led[LED_COUNT-2:0], r_led[LED_COUNT-1]};
  assign w_rotr = {r_led[0], r_led[LED_COUNT-1:1]};

  // Bounce turns around when the lit end is reached, stepping away on the same strobe.
  always_comb begin
    w_led_step = r_led;
    w_dir_step = r_dir;
    case (r_mode)
      MODE_HOLD: w_led_step = r_led;
      MODE_ROTL: w_led_step = w_rotl;
      MODE_ROTR: w_led_step = w_rotr;
      MODE_BOUNCE: begin
        if (r_dir == DIR_LEFT) begin
          if (r_led[LED_COUNT-1]) begin
            w_dir_step = DIR_RIGHT;
            w_led_step = w_rotr;
          end else begin
            w_led_step = w_rotl;
          end
        end else begin
          if (r_led[0]) begin
            w_dir_step = DIR_LEFT;
            w_led_step = w_rotl;
          end else begin
            w_led_step = w_rotr;
          end
        end
      end
      default: w_led_step = r_led;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_led  <= LED_COUNT'(1);
      r_stb  <= 1'b0;
      r_mode <= MODE_HOLD;
      r_div  <= '0;
      r_pat  <= '0;
      r_dir  <= DIR_LEFT;
    end else begin
      r_stb <= w_tc;
      if (w_accept) begin
        r_mode <= mode_t'(i_cmd_mode);
        r_div  <= i_cmd_div;
        r_pat  <= i_cmd_pattern;
      end
      if (r_state == ST_LOAD) begin
        r_led <= r_pat;
        r_dir <= DIR_LEFT;
      end else if (w_tc) begin
        r_led <= w_led_step;
        r_dir <= w_dir_step;
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Purpose: directed self-checking bench for led_seq_ctrl (LED_COUNT=4, DIV_WIDTH=16).
// Ports:   none; drives the DUT from initial blocks and samples 1 ns after each rising edge.
// Output:  FAIL lines per mismatch and one summary line.
module tb_led_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_mode;
  logic [15:0] i_cmd_div;
  logic [3:0]  i_cmd_pattern;
  logic        i_pause;
  logic [3:0]  o_led;
  logic        o_stb;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  led_seq_ctrl #(.LED_COUNT(4), .DIV_WIDTH(16)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_mode    (i_cmd_mode),
    .i_cmd_div     (i_cmd_div),
    .i_cmd_pattern (i_cmd_pattern),
    .i_pause       (i_pause),
    .o_led         (o_led),
    .o_stb         (o_stb),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents a command for exactly one edge (ready is high outside LOAD).
  task automatic issue(input logic [1:0] mode, input logic [15:0] div, input logic [3:0] pat);
    i_cmd_valid   = 1'b1;
    i_cmd_mode    = mode;
    i_cmd_div     = div;
    i_cmd_pattern = pat;
    tick();
    i_cmd_valid   = 1'b0;
  endtask

  logic [3:0] exp_rotl [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_bnc  [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    int stb_seen;
    i_rst         = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd_mode    = 2'd0;
    i_cmd_div     = 16'd0;
    i_cmd_pattern = 4'd0;
    i_pause       = 1'b0;
    #12;
    check("rst_led", o_led, 4'b0001);
    check("rst_busy", o_busy, 1'b0);
    i_rst = 1'b0;

    // Idle with no command: nothing moves for 50 clocks.
    stb_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_stb) stb_seen++;
    end
    check("idle_stb_count", stb_seen, 0);
    check("idle_led", o_led, 4'b0001);
    check("idle_busy", o_busy, 1'b0);
    check("idle_ready", o_cmd_ready, 1'b1);

    // ROTL div=2: step every 3 edges after LOAD; live div change must be ignored.
    issue(2'd1, 16'd2, 4'b0001);
    i_cmd_div = 16'd9;
    check("rotl_load_ready", o_cmd_ready, 1'b0);
    check("rotl_load_busy", o_busy, 1'b1);
    tick();
    check("rotl_after_load_led", o_led, 4'b0001);
    check("rotl_after_load_stb", o_stb, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rotl_gap1_stb", o_stb, 1'b0);
      tick();
      check("rotl_gap2_stb", o_stb, 1'b0);
      check("rotl_gap2_led", o_led, (k == 0) ? 4'b0001 : exp_rotl[k-1]);
      tick();
      check("rotl_step_led", o_led, exp_rotl[k]);
      check("rotl_step_stb", o_stb, 1'b1);
    end

    // BOUNCE div=0, issued mid-run: one step per cycle, turning at each end.
    issue(2'd3, 16'd0, 4'b0001);
    tick();
    check("bnc_load_led", o_led, 4'b0001);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("bnc_led", o_led, exp_bnc[k]);
      check("bnc_stb", o_stb, 1'b1);
    end

    // ROTR div=3 with a 10-edge pause while the counter holds 1.
    issue(2'd2, 16'd3, 4'b0001);
    tick();                       // LOAD edge: counter = 3
    tick();                       // counter 2
    tick();                       // counter 1
    check("pause_pre_led", o_led, 4'b0001);
    i_pause = 1'b1;
    stb_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_stb) stb_seen++;
    end
    check("pause_stb_count", stb_seen, 0);
    check("pause_led", o_led, 4'b0001);
    check("pause_busy", o_busy, 1'b1);
    i_pause = 1'b0;
    tick();                       // PAUSE -> RUN, counter still 1
    check("resume_e1_stb", o_stb, 1'b0);
    tick();                       // counter 1 -> 0
    check("resume_e2_stb", o_stb, 1'b0);
    tick();                       // step
    check("resume_step_stb", o_stb, 1'b1);
    check("resume_step_led", o_led, 4'b1000);

    // ROTL div=0, then HOLD 1010 on an edge where the counter is 0.
    issue(2'd1, 16'd0, 4'b0001);
    tick();
    tick();
    check("rotl0_led", o_led, 4'b0010);
    check("rotl0_stb", o_stb, 1'b1);
    issue(2'd0, 16'd0, 4'b1010);
    check("acc_vs_stb_led", o_led, 4'b0010);
    check("acc_vs_stb_stb", o_stb, 1'b0);
    check("acc_vs_stb_ready", o_cmd_ready, 1'b0);
    tick();
    check("hold_load_led", o_led, 4'b1010);
    check("hold_load_ready", o_cmd_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_led", o_led, 4'b1010);
      check("hold_stb", o_stb, 1'b1);
    end

    // All-zero pattern stays dark but keeps strobing.
    issue(2'd1, 16'd0, 4'b0000);
    tick();
    tick();
    check("zero_led", o_led, 4'b0000);
    check("zero_stb", o_stb, 1'b1);
    tick();
    check("zero_stb2", o_stb, 1'b1);

    // Asynchronous reset between edges while strobing.
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_led", o_led, 4'b0001);
    check("arst_stb", o_stb, 1'b0);
    check("arst_busy", o_busy, 1'b0);
    check("arst_ready", o_cmd_ready, 1'b1);
    tick();
    tick();
    #2;
    i_rst = 1'b0;
    tick();
    check("post_rst_led", o_led, 4'b0001);
    check("post_rst_stb", o_stb, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
